pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
// Sequences the PC redirect produced by the EX-stage branch unit. Accepts a
// taken branch/jal/jalr, holds the target until fetch can take it, loads the
// PC, then squashes wrong-path instructions in IF/ID and ID/EX for a fixed
// drain window. Sits between the branch unit, the PC register and the hazard
// unit. Also keeps saturating branch statistics.
// PARAMETERS
// PC_W          9   width of the PC register fed by pc_next
// FLUSH_CYCLES  2   cycles flushes stay high after the PC load (>=1)
// CNT_W         16  width of the statistics counters
// PORTS
// clk           in   1      single clock, rising edge
// reset         in   1      synchronous, active-high
// ex_valid      in   1      EX stage holds a valid (non-bubble) instruction
// Branch        in   1      EX instruction is a conditional branch
// Jal_Sel       in   1      EX instruction is jal
// Jalr_Sel      in   1      EX instruction is jalr
// PcSel         in   1      branch unit: control transfer taken
// BrPC          in   32     branch unit: redirect target
// fetch_ready   in   1      PC register may be written this cycle (no stall)
// pc_load       out  1      write pc_next into PC this cycle
// pc_next       out  PC_W   latched redirect target
// flush_ifid    out  1      squash IF/ID register
// flush_idex    out  1      squash ID/EX register
// busy          out  1      redirect in progress (state != IDLE)
// misalign_err  out  1      1-cycle pulse: accepted target had BrPC[1:0]!=0
// branch_cnt    out  CNT_W  control-transfer instructions seen
// taken_cnt     out  CNT_W  redirects accepted
// BEHAVIOUR
// - Reset: state=IDLE, pc_next=0, every output 0, counters 0. Reset beats
//   any in-flight redirect (pending target discarded, no pc_load issued).
// - FSM IDLE -> LOAD -> FLUSH -> IDLE; busy = (state!=IDLE).
// - IDLE: accept = ex_valid & PcSel. On accept: pc_next<=BrPC[PC_W-1:0]
//   (upper bits dropped), state<=LOAD, taken_cnt++, misalign_err<=|BrPC[1:0].
//   PcSel with ex_valid=0 is ignored.
// - LOAD: flush_ifid=flush_idex=1; pc_load=fetch_ready (combinational).
//   fetch_ready=0: stay LOAD, pc_next held, flushes held. fetch_ready=1:
//   FLUSH_CYCLES==1 -> IDLE, else FLUSH with cnt<=FLUSH_CYCLES-2.
// - FLUSH: flushes=1, pc_load=0; cnt==0 -> IDLE, else cnt--.
// - Outside LOAD/FLUSH both flushes=0; pc_load=0 outside LOAD.
// - Latency: accept at edge N -> pc_load earliest in cycle N+1; flushes
//   span exactly 1+FLUSH_CYCLES-1 cycles after the load cycle inclusive of
//   LOAD wait cycles.
// - Requests while busy are wrong-path and ignored (no state/counter change).
// - branch_cnt++ when ex_valid & (Branch|Jal_Sel|Jalr_Sel) & state==IDLE.
// - Both counters saturate at all-ones; no wrap.
// - Back-to-back: redirect in the cycle IDLE is re-entered is accepted.
// TESTING
// - Taken beq, BrPC=0x40, fetch_ready=1 -> pc_load@N+1 pc_next=0x40, flushes
//   high N+1..N+2 (FLUSH_CYCLES=2), busy low N+3, taken_cnt=1.
// - Not-taken branch (Branch=1,PcSel=0) -> no pc_load/flush, branch_cnt=1.
// - Redirect with fetch_ready low 3 cycles -> LOAD held, pc_next stable,
//   single pc_load on the first ready cycle, then FLUSH.
// - Second PcSel during LOAD/FLUSH -> ignored; pc_next and counters unchanged.
// - jalr BrPC=0x1_0006 (PC_W=9) -> pc_next=0x006, misalign_err one pulse.
// - reset asserted in LOAD -> next cycle IDLE, no pc_load, counters 0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// EX-stage redirect sequencer: latches a taken target, loads the PC when fetch is ready, then squashes IF/ID and ID/EX for a fixed drain window.
// Latency: accept at edge N -> pc_load earliest in cycle N+1; wrong-path requests while busy are dropped; fetch_ready=0 holds LOAD.
module pc_redirect_ctrl #(
    parameter int PC_W         = 9,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             Branch,
    input  logic             Jal_Sel,
    input  logic             Jalr_Sel,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             fetch_ready,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_next,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // cnt holds at most FLUSH_CYCLES-2
    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_next_q, pc_next_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             accept;
    logic             is_cti;
    logic             unused_brpc_hi;

    assign unused_brpc_hi = ^BrPC[31:PC_W];

    assign accept = (state_q == IDLE) && ex_valid && PcSel;
    assign is_cti = (state_q == IDLE) && ex_valid && (Branch || Jal_Sel || Jalr_Sel);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_next_d    = pc_next_q;
        misalign_d   = 1'b0;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        pc_load      = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;

        if (is_cti && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pc_next_d  = BrPC[PC_W-1:0];
                    misalign_d = |BrPC[1:0];
                    state_d    = LOAD;
                    if (taken_cnt_q != {CNT_W{1'b1}}) begin
                        taken_cnt_d = taken_cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                pc_load    = fetch_ready;
                if (fetch_ready) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 2);
                    end
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pc_next_q    <= '0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_next_q    <= pc_next_d;
            misalign_q   <= misalign_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign pc_next      = pc_next_q;
    assign busy         = (state_q != IDLE);
    assign misalign_err = misalign_q;
    assign branch_cnt   = branch_cnt_q;
    assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: expected targets queued at accept, checked at each pc_load.
module tb_pc_redirect_ctrl;

    localparam int PC_W  = 9;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid, Branch, Jal_Sel, Jalr_Sel, PcSel, fetch_ready;
    logic [31:0]      BrPC;
    logic             pc_load, flush_ifid, flush_idex, busy, misalign_err;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_load = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .Branch(Branch),
        .Jal_Sel(Jal_Sel), .Jalr_Sel(Jalr_Sel), .PcSel(PcSel), .BrPC(BrPC),
        .fetch_ready(fetch_ready), .pc_load(pc_load), .pc_next(pc_next),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .busy(busy),
        .misalign_err(misalign_err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every pc_load must match the oldest accepted target.
    always @(negedge clk) begin
        if (!reset && pc_load) begin
            n_load++;
            if (exp_q.size() == 0) chk("unexpected_pc_load", 32'd1, 32'd0);
            else chk("pc_next_at_load", 32'(pc_next), exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic sel, input logic [31:0] pc);
        ex_valid = v; Branch = br; Jal_Sel = jal; Jalr_Sel = jalr; PcSel = sel; BrPC = pc;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_outs(input string tag, input logic ld, input logic fl, input logic bz);
        @(negedge clk);
        chk({tag, "_pc_load"}, 32'(pc_load), 32'(ld));
        chk({tag, "_flush_ifid"}, 32'(flush_ifid), 32'(fl));
        chk({tag, "_flush_idex"}, 32'(flush_idex), 32'(fl));
        chk({tag, "_busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        reset = 1'b1;
        fetch_ready = 1'b1;
        quiet();
        step(); step();
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_pc_next", 32'(pc_next), 32'h0);
        chk("reset_cnts", {24'h0, branch_cnt, taken_cnt}, 32'h0);
        chk("reset_misalign", 32'(misalign_err), 32'h0);
        step();
        reset = 1'b0;

        // taken beq to 0x40
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        exp_q.push_back(32'h40);
        step(); quiet();
        chk_outs("beq_n1", 1'b1, 1'b1, 1'b1);
        chk("beq_taken_cnt", 32'(taken_cnt), 32'd1);
        chk("beq_misalign", 32'(misalign_err), 32'd0);
        step(); chk_outs("beq_n2", 1'b0, 1'b1, 1'b1);
        step(); chk_outs("beq_n3", 1'b0, 1'b0, 1'b0);

        // not-taken branch
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
        step(); quiet();
        chk_outs("nt", 1'b0, 1'b0, 1'b0);
        chk("nt_branch_cnt", 32'(branch_cnt), 32'd2);
        chk("nt_taken_cnt", 32'(taken_cnt), 32'd1);

        // PcSel without ex_valid is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44);
        step(); quiet();
        chk_outs("bubble", 1'b0, 1'b0, 1'b0);

        // fetch stalled for 3 cycles, with wrong-path requests during LOAD and FLUSH
        fetch_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h88);
        exp_q.push_back(32'h88);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1fc);
        chk_outs("stall1", 1'b0, 1'b1, 1'b1);
        chk("stall1_pc_next", 32'(pc_next), 32'h88);
        step(); quiet();
        chk_outs("stall2", 1'b0, 1'b1, 1'b1);
        chk("stall2_pc_next", 32'(pc_next), 32'h88);
        step();
        chk_outs("stall3", 1'b0, 1'b1, 1'b1);
        step(); fetch_ready = 1'b1;
        chk_outs("stall_ready", 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h120);
        chk_outs("stall_flush", 1'b0, 1'b1, 1'b1);
        step(); quiet();
        chk_outs("stall_idle", 1'b0, 1'b0, 1'b0);
        chk("wrongpath_branch_cnt", 32'(branch_cnt), 32'd3);
        chk("wrongpath_taken_cnt", 32'(taken_cnt), 32'd2);
        chk("wrongpath_pc_next", 32'(pc_next), 32'h88);

        // misaligned jalr with truncated target, then back-to-back jal on IDLE re-entry
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0001_0006);
        exp_q.push_back(32'h006);
        step(); quiet();
        chk_outs("jalr_load", 1'b1, 1'b1, 1'b1);
        chk("jalr_misalign", 32'(misalign_err), 32'd1);
        step();
        chk_outs("jalr_flush", 1'b0, 1'b1, 1'b1);
        chk("jalr_misalign_pulse", 32'(misalign_err), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
        exp_q.push_back(32'h100);
        chk_outs("b2b_idle", 1'b0, 1'b0, 1'b0);
        step(); quiet();
        chk_outs("b2b_load", 1'b1, 1'b1, 1'b1);
        step(); step();
        chk("b2b_taken_cnt", 32'(taken_cnt), 32'd4);

        // reset in LOAD discards the pending target
        fetch_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55);
        step(); quiet();
        chk_outs("rst_load", 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        chk_outs("rst_after", 1'b0, 1'b0, 1'b0);
        chk("rst_cnts", {24'h0, branch_cnt, taken_cnt}, 32'h0);
        chk("rst_pc_next", 32'(pc_next), 32'h0);
        reset = 1'b0;
        fetch_ready = 1'b1;
        step();
        chk_outs("rst_release", 1'b0, 1'b0, 1'b0);

        // counters saturate at all-ones
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'(i * 4));
            exp_q.push_back(32'(i * 4));
            step(); quiet();
            step(); step();
        end
        @(negedge clk);
        chk("sat_taken_cnt", 32'(taken_cnt), 32'hf);
        chk("sat_branch_cnt", 32'(branch_cnt), 32'hf);

        step(); step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_loads", 32'(n_load), 32'd21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
